channel_scan_sequencer: RTL
===========================

Name: channel_scan_sequencer

Overview:
- Upstream stage of the 3-to-8 select decoder.
- Steps a 3-bit binary channel index through the enabled channels of an 8-bit mask, holding each channel for a programmable dwell time.
- Drives the decoder's select input, plus a valid qualifier that downstream logic uses to gate the decoded lines.
- Supports start/stop control and flags a pulse at the end of each scan frame.

Parameters:
- SEL_W, 3, width of the channel index driven to the decoder.
- N_CH, 8, number of channels; always 2**SEL_W.
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin scanning; sampled only in IDLE.
- stop  input  1  request to end scanning; sampled in any state.
- dwell  input  DWELL_W  hold time per channel, in cycles minus 1.
- ch_mask  input  N_CH  bit k set means channel k is scanned.
- sel  output  SEL_W  binary channel index to the decoder.
- sel_valid  output  1  sel is a live channel.
- busy  output  1  sequencer is not idle.
- frame_done  output  1  one-cycle pulse on the last cycle of a frame.

Behaviour:
- Reset (asynchronous): state=IDLE, sel=0, sel_valid=0, busy=0, frame_done=0, dwell counter=0, stop_pending=0.
- States: IDLE and SCAN; busy = (state==SCAN); sel_valid = (state==SCAN). All outputs are registered.
- IDLE to SCAN:
  - Occurs on start=1 with stop=0 and ch_mask != 0.
  - Next cycle: sel = lowest set bit of ch_mask; counter loaded from dwell.
  - Latency from start to sel_valid is 1 cycle.
- start with ch_mask == 0, or start and stop together in IDLE: ignored, stay IDLE.
- SCAN:
  - Counter decrements each cycle, so each channel is held dwell+1 cycles; dwell=0 gives 1 cycle per channel.
  - Last cycle of a dwell is when counter==0.
  - On the last cycle, the next enabled channel is found by a circular search of the current ch_mask, starting at sel+1 and wrapping at N_CH-1 to 0.
  - The next cycle then has sel = that channel and counter = dwell, with no bubble.
- Mask and dwell timing: ch_mask is re-sampled at every advance; dwell is re-sampled at every channel entry. Mid-dwell changes take effect at the next advance.
- Single enabled channel: sel stays constant; counter reloads every dwell+1 cycles.
- Wrap index arithmetic is modulo N_CH, with no out-of-range index.
- frame_done:
  - Asserted for one cycle on the last dwell cycle of a channel whose next enabled channel index is <= the current sel (i.e. the search wraps).
  - A single enabled channel therefore gives frame_done once every dwell+1 cycles.
- stop:
  - stop=1 in SCAN sets stop_pending.
  - At the end of the current channel's dwell, go to IDLE: sel=0, sel_valid=0, stop_pending cleared. The current channel always completes its dwell.
  - frame_done still fires on that cycle if the wrap condition holds.
- Mask cleared mid-scan: if ch_mask == 0 at an advance, go to IDLE as for stop. frame_done is not asserted.
- Reset mid-scan: immediate return to reset values; no partial pulses.

Decomposition:
- Shared package (scan_pkg):
  - Constants SEL_W=3, N_CH=8.
  - State enum {IDLE, SCAN}.
  - The sel-to-line mapping constant shared with the decoder's verification model.
- One sub-module, next_channel_finder: purely combinational circular priority search.
  - Inputs: mask, current index.
  - Outputs: next index, wrapped flag, none-found flag.

Test Plan:
- Reset then start, mask=8'hFF, dwell=0: sel steps 0,1,…,7,0 one per cycle, starting 1 cycle after start. frame_done high on the cycle sel==7.
- Sparse mask, mask=8'b1010_0100, dwell=2: sel = 2,2,2,5,5,5,7,7,7,2… frame_done on the third cycle of sel==7.
- Stop mid-dwell: mask=8'hFF, dwell=3, stop pulsed on the 2nd cycle of sel==4. sel==4 held 4 cycles total, then sel_valid=0, busy=0, sel=0.
- Mask=0 with start: no state change, busy stays 0. Then mask=8'h01 with start: sel=0 constantly, frame_done every dwell+1 cycles.
- Mask change mid-frame: mask 8'hFF changed to 8'h11 while sel==2. The next advance goes to 4, then 0, with frame_done at the 4 to 0 wrap. Then clear mask to 0: IDLE at the next advance.
- Asynchronous reset asserted mid-dwell, between clock edges: all outputs go to 0 immediately. start and stop asserted together in IDLE: no transition.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared constants and types for the channel scan sequencer and its decoder model.
package scan_pkg;

    localparam int unsigned SEL_W   = 3;
    localparam int unsigned N_CH    = 1 << SEL_W;
    localparam int unsigned DWELL_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // One-hot decoder line driven for each sel value (index = sel).
    localparam logic [N_CH-1:0] SEL_LINE_MAP [N_CH] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
    };

endpackage

// File: rtl/next_channel_finder.sv
// Circular priority search: first set mask bit after cur_idx, wrapping to 0.
module next_channel_finder
    import scan_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] cur_idx,
    output logic [SEL_W-1:0] next_idx_c,
    output logic             wrapped_c,
    output logic             none_c
);

    logic [SEL_W-1:0] probe;
    logic             found;

    // Scan cur_idx+1 .. cur_idx+N_CH; the last probe is cur_idx itself.
    always_comb begin
        next_idx_c = '0;
        found      = 1'b0;
        probe      = '0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            probe = cur_idx + SEL_W'(k);
            if (!found && mask[probe]) begin
                next_idx_c = probe;
                found      = 1'b1;
            end
        end
    end

    assign none_c    = ~found;
    assign wrapped_c = found && (next_idx_c <= cur_idx);

endmodule

// File: rtl/channel_scan_sequencer.sv
// Steps a select index through the enabled channels, holding each for dwell+1 cycles.
module channel_scan_sequencer
    import scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [N_CH-1:0]    ch_mask,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               frame_done
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               sel_valid_q, sel_valid_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               stop_pending_q, stop_pending_d;

    logic [SEL_W-1:0]   search_from;
    logic [SEL_W-1:0]   adv_idx;
    logic               adv_wrapped;
    logic               adv_none;
    logic [SEL_W-1:0]   peek_idx;
    logic               peek_wrapped;
    logic               peek_none;
    logic               unused_finder;

    // From IDLE, searching after N_CH-1 yields the lowest set bit.
    assign search_from = (state_q == IDLE) ? SEL_W'(N_CH - 1) : sel_q;

    next_channel_finder u_adv (
        .mask       (ch_mask),
        .cur_idx    (search_from),
        .next_idx_c (adv_idx),
        .wrapped_c  (adv_wrapped),
        .none_c     (adv_none)
    );

    // Looks ahead from the channel being entered so frame_done lines up with its last cycle.
    next_channel_finder u_peek (
        .mask       (ch_mask),
        .cur_idx    (sel_d),
        .next_idx_c (peek_idx),
        .wrapped_c  (peek_wrapped),
        .none_c     (peek_none)
    );

    assign unused_finder = ^{adv_wrapped, peek_idx, peek_none};

    // Next-state and next-output computation.
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        cnt_d          = cnt_q;
        sel_valid_d    = sel_valid_q;
        busy_d         = busy_q;
        stop_pending_d = stop_pending_q;
        case (state_q)
            IDLE: begin
                if (start && !stop && (ch_mask != '0)) begin
                    state_d        = SCAN;
                    sel_d          = adv_idx;
                    cnt_d          = dwell;
                    sel_valid_d    = 1'b1;
                    busy_d         = 1'b1;
                    stop_pending_d = 1'b0;
                end
            end
            SCAN: begin
                if (stop) begin
                    stop_pending_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (adv_none || stop || stop_pending_q) begin
                    state_d        = IDLE;
                    sel_d          = '0;
                    cnt_d          = '0;
                    sel_valid_d    = 1'b0;
                    busy_d         = 1'b0;
                    stop_pending_d = 1'b0;
                end else begin
                    sel_d = adv_idx;
                    cnt_d = dwell;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pulse on the last dwell cycle of a channel whose successor wraps.
    assign frame_done_d = (state_d == SCAN) && (cnt_d == '0) && peek_wrapped;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            sel_q          <= '0;
            cnt_q          <= '0;
            sel_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            stop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            cnt_q          <= cnt_d;
            sel_valid_q    <= sel_valid_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
